// File: rtl/addsub_accum.sv
// addsub_accum: signed add/subtract vector accumulator with valid/ready
// handshakes on both sides.
//
// Operands stream in on the input handshake. Each accepted operand is added
// to, or subtracted from, the running accumulator. The operand flagged
// in_last closes the vector. The result then waits in HOLD until the
// downstream handshake completes. Leaving HOLD clears the accumulator, the
// sticky overflow flag and the element counter.
//
// Parameters:
//   WIDTH  two's-complement width of operands, accumulator and result
//   CNT_W  width of the saturating element counter
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operand available
//   in_ready   block accepts an operand (state ACC)
//   in_data    signed operand
//   in_sub     1 = subtract in_data, 0 = add in_data
//   in_last    operand is the final element of the vector
//   out_valid  vector result available (state HOLD)
//   out_ready  downstream accepts the result
//   out_data   signed vector result
//   out_ovf    sticky overflow seen during the vector
//   out_count  operands accepted in the vector (saturating)
//
// Build option:
//   ADDSUB_ACCUM_SATURATE_EN  clamp the accumulator on overflow instead of
//                             wrapping modulo 2^WIDTH

module addsub_accum #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef ADDSUB_ACCUM_SATURATE_EN
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic             sticky, sticky_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic [WIDTH-1:0] sum;
  logic             op_ovf;
  logic             acc_neg;

  // Datapath: modular add/sub plus overflow detect. Subtract overflow is
  // judged on the original operand signs rather than on the negated operand,
  // so that subtracting the most negative value from acc >= 0 is flagged.
  always_comb begin
    acc_neg = acc[WIDTH-1];
    if (in_sub) begin
      sum    = acc - in_data;
      op_ovf = (acc_neg != in_data[WIDTH-1]) && (sum[WIDTH-1] != acc_neg);
    end else begin
      sum    = acc + in_data;
      op_ovf = (acc_neg == in_data[WIDTH-1]) && (sum[WIDTH-1] != acc_neg);
    end
  end

  // Next-state and next-value logic.
  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    sticky_nxt = sticky;
    cnt_nxt    = cnt;
    case (state)
      ACC: begin
        if (in_valid) begin
`ifdef ADDSUB_ACCUM_SATURATE_EN
          if (op_ovf) begin
            acc_nxt = acc_neg ? MIN_NEG : MAX_POS;
          end else begin
            acc_nxt = sum;
          end
`else
          acc_nxt = sum;
`endif
          sticky_nxt = sticky | op_ovf;
          cnt_nxt    = (cnt == '1) ? cnt : cnt + CNT_ONE;
          if (in_last) begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt  = ACC;
          acc_nxt    = '0;
          sticky_nxt = 1'b0;
          cnt_nxt    = '0;
        end
      end
      default: begin
        state_nxt = ACC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ACC;
      acc    <= '0;
      sticky <= 1'b0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      sticky <= sticky_nxt;
      cnt    <= cnt_nxt;
    end
  end

  always_comb begin
    in_ready  = (state == ACC);
    out_valid = (state == HOLD);
    out_data  = acc;
    out_ovf   = sticky;
    out_count = cnt;
  end

endmodule

// File: tb/tb_addsub_accum.sv
// Self-checking bench for addsub_accum. The reference model tracks the true
// integer sum per vector and applies wrap or clamp from the mathematical
// result range.

module tb_addsub_accum;

  localparam int W  = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_sub;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_ovf;
  logic [CW-1:0] out_count;

  int passed = 0;
  int total  = 0;

  // Reference model state.
  int m_acc;
  bit m_ovf;
  int m_cnt;

  logic [26:0] got;
  logic [26:0] exp;

  addsub_accum #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sub    (in_sub),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  function automatic void m_clear();
    m_acc = 0;
    m_ovf = 1'b0;
    m_cnt = 0;
  endfunction

  function automatic void m_step(int d, bit s);
    int t;
    int w;
    t = s ? (m_acc - d) : (m_acc + d);
    if (t > 32767 || t < -32768) begin
      m_ovf = 1'b1;
`ifdef ADDSUB_ACCUM_SATURATE_EN
      m_acc = (m_acc >= 0) ? 32767 : -32768;
`else
      w = t & 32'h0000_FFFF;
      if (w >= 32768) w = w - 65536;
      m_acc = w;
`endif
    end else begin
      m_acc = t;
    end
    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
  endfunction

  // Expected {in_ready, out_valid, out_ovf, out_count, out_data} in HOLD.
  function automatic logic [26:0] m_hold();
    return {1'b0, 1'b1, m_ovf, 8'(m_cnt), 16'(m_acc)};
  endfunction

  function automatic logic [26:0] sample();
    return {in_ready, out_valid, out_ovf, out_count, out_data};
  endfunction

  task automatic push(int d, bit s, bit l);
    in_valid = 1'b1;
    in_data  = 16'(d);
    in_sub   = s;
    in_last  = l;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    m_step(d, s);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    m_clear();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 16'h1234; in_sub = 1'b0;
    in_last = 1'b1; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    got = sample(); exp = {1'b1, 1'b0, 1'b0, 8'd0, 16'd0}; total++;
    if (got !== exp) $display("FAIL reset_state: got %h expected %h", got, exp);
    else passed++;
    rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    got = sample(); total++;
    if (got !== exp) $display("FAIL reset_idle: got %h expected %h", got, exp);
    else passed++;
    m_clear();
  endtask

  task automatic test_basic();
    push(5, 0, 0);
    push(3, 1, 0);
    push(10, 0, 1);
    got = sample(); exp = m_hold(); total++;
    if (got !== exp) $display("FAIL basic_model: got %h expected %h", got, exp);
    else passed++;
    exp = {1'b0, 1'b1, 1'b0, 8'd3, 16'd12}; total++;
    if (got !== exp) $display("FAIL basic_fixed: got %h expected %h", got, exp);
    else passed++;
    release_out();
  endtask

  task automatic test_overflow();
    logic [15:0] ed;
`ifdef ADDSUB_ACCUM_SATURATE_EN
    ed = 16'h7FFF;
`else
    ed = 16'h8000;
`endif
    push(32767, 0, 0);
    push(1, 0, 1);
    got = sample(); exp = {1'b0, 1'b1, 1'b1, 8'd2, ed}; total++;
    if (got !== exp) $display("FAIL add_ovf: got %h expected %h", got, exp);
    else passed++;
    release_out();
    push(-32768, 1, 1);
    got = sample(); exp = {1'b0, 1'b1, 1'b1, 8'd1, ed}; total++;
    if (got !== exp) $display("FAIL sub_min_ovf: got %h expected %h", got, exp);
    else passed++;
    exp = m_hold(); total++;
    if (got !== exp) $display("FAIL sub_min_model: got %h expected %h", got, exp);
    else passed++;
    release_out();
  endtask

  task automatic test_hold_stall();
    push(100, 0, 0);
    push(40, 1, 1);
    // Offer a single-element vector while the result is pending.
    in_valid = 1'b1; in_data = 16'd4; in_sub = 1'b0; in_last = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      got = sample(); exp = m_hold(); total++;
      if (got !== exp) $display("FAIL hold_stable_%0d: got %h expected %h", i, got, exp);
      else passed++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    m_clear();
    got = sample(); exp = {1'b1, 1'b0, 1'b0, 8'd0, 16'd0}; total++;
    if (got !== exp) $display("FAIL release_clear: got %h expected %h", got, exp);
    else passed++;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    m_step(4, 0);
    got = sample(); exp = {1'b0, 1'b1, 1'b0, 8'd1, 16'd4}; total++;
    if (got !== exp) $display("FAIL after_stall: got %h expected %h", got, exp);
    else passed++;
    release_out();
  endtask

  task automatic test_reset_mid();
    push(1000, 0, 0);
    push(77, 1, 0);
    rst_n = 1'b0; in_valid = 1'b1; in_data = 16'd5; in_last = 1'b1;
    @(posedge clk); #1;
    got = sample(); exp = {1'b1, 1'b0, 1'b0, 8'd0, 16'd0}; total++;
    if (got !== exp) $display("FAIL reset_mid: got %h expected %h", got, exp);
    else passed++;
    rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    m_clear();
    push(7, 0, 0);
    push(2, 0, 1);
    got = sample(); exp = {1'b0, 1'b1, 1'b0, 8'd2, 16'd9}; total++;
    if (got !== exp) $display("FAIL fresh_vector: got %h expected %h", got, exp);
    else passed++;
    release_out();
  endtask

  task automatic test_count_sat();
    for (int i = 1; i <= 300; i++) push(1, 0, i == 300);
    got = sample(); exp = {1'b0, 1'b1, 1'b0, 8'd255, 16'd300}; total++;
    if (got !== exp) $display("FAIL count_sat: got %h expected %h", got, exp);
    else passed++;
    release_out();
  endtask

  task automatic test_random();
    int len;
    int d;
    bit s;
    for (int v = 0; v < 40; v++) begin
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        repeat ($urandom_range(0, 2)) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        // Mix near-limit magnitudes in to exercise overflow often.
        if ($urandom_range(0, 3) == 0) d = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
        else d = int'($urandom_range(0, 65535)) - 32768;
        s = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        push(d, s, k == len - 1);
        out_ready = 1'b0;
      end
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 16'($urandom_range(0, 65535));
        in_last  = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      in_valid = 1'b0; in_last = 1'b0;
      got = sample(); exp = m_hold(); total++;
      if (got !== exp) $display("FAIL random_vec_%0d: got %h expected %h", v, got, exp);
      else passed++;
      release_out();
    end
  endtask

  initial begin
    m_clear();
    test_reset();
    test_basic();
    test_overflow();
    test_hold_stall();
    test_reset_mid();
    test_count_sat();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
